ram_port_arbiter: RTL and testbench

- Sits directly upstream of the single-port data RAM in the Flappy Bird ARMv4 system.
- Arbitrates two masters onto the one RAM port: the CPU data port (master A) and the VGA sprite/state fetcher (master B).
- Drives the RAM write-enable, address and write-data lines.
- Returns RAM read data to whichever master issued the read, with a fixed pipeline latency.

---
 rtl/ram_port_arbiter_if.sv | 16 +
 rtl/ram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Request/response bundle between one RAM master and the ram_port_arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM (CPU = a, video = b).
// ARB_ROUND_ROBIN_EN selects alternating priority instead of A-first with MAX_WAIT anti-starvation.
module ram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  ram_port_arbiter_if.slave  a,
  ram_port_arbiter_if.slave  b,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata
);

  logic              b_pri;
  logic              a_win;
  logic              b_win;
  logic              grant;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              vld_p0;
  logic              own_p0;
  logic              vld_p1;
  logic              own_p1;

`ifdef ARB_ROUND_ROBIN_EN
  // last_a=0 after reset means B is treated as the last winner, so A takes the first contention
  logic last_a;

  assign b_pri = last_a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_a <= 1'b0;
    end else if (a.req && b.req) begin
      last_a <= a_win;
    end
  end
`else
  logic [7:0] wait_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'(MAX_WAIT)) ? cnt : cnt + 8'd1;
  endfunction

  assign b_pri = (wait_cnt == 8'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
    end else if (b.req && !b_win) begin
      wait_cnt <= sat_inc(wait_cnt);
    end else begin
      wait_cnt <= 8'd0;
    end
  end
`endif

  // grants are forced low while reset is asserted
  assign a_win = rst & a.req & ~(b.req & b_pri);
  assign b_win = rst & b.req & ~(a.req & ~b_pri);
  assign grant = a_win | b_win;
  assign a.gnt = a_win;
  assign b.gnt = b_win;

  assign win_we    = b_win ? b.we    : a.we;
  assign win_addr  = b_win ? b.addr  : a.addr;
  assign win_wdata = b_win ? b.wdata : a.wdata;

  // stage p0: issue winner to the RAM port, tag reads with their owner (1 = B)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      vld_p0    <= 1'b0;
      own_p0    <= 1'b0;
    end else begin
      ram_we <= grant & win_we;
      vld_p0 <= grant & ~win_we;
      own_p0 <= b_win;
      if (grant) begin
        ram_addr  <= win_addr;
        ram_wdata <= win_wdata;
      end
    end
  end

  // stage p1: RAM data for the tagged read is on ram_rdata during this stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      own_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      own_p1 <= own_p0;
    end
  end

  // stage p2: capture read data for the owner only; the other master's rdata holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a.rvalid <= 1'b0;
      a.rdata  <= '0;
      b.rvalid <= 1'b0;
      b.rdata  <= '0;
    end else begin
      a.rvalid <= vld_p1 & ~own_p1;
      b.rvalid <= vld_p1 & own_p1;
      if (vld_p1 && !own_p1) begin
        a.rdata <= ram_rdata;
      end
      if (vld_p1 && own_p1) begin
        b.rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a grant-order memory model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_bus ();
  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_bus ();

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a_bus),
    .b         (b_bus),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 3) return 32'h0000_EA99;
    if (i == 5) return 32'h0000_1234;
    return (32'(i) * 32'h0101_0101) ^ 32'h5A00_0000;
  endfunction

  // synchronous RAM model: contents loaded until init_done, then one read/write port
  logic        init_done = 1'b0;
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: memory updated in grant order, reads due 3 cycles after grant
  logic [31:0] refmem [256];
  logic        slot_v [4];
  logic        slot_b [4];
  logic [31:0] slot_d [4];
  logic        exp_we;
  logic [31:0] exp_addr, exp_wd, exp_ard, exp_brd;
  int          denied;
  logic        last_a;
  logic        last_ag, last_bg;
  logic        obs_bg;
  int          cyc = 0;

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      slot_v[i] = 1'b0; slot_b[i] = 1'b0; slot_d[i] = '0;
    end
    exp_we = 1'b0; exp_addr = '0; exp_wd = '0; exp_ard = '0; exp_brd = '0;
    denied = 0; last_a = 1'b0; last_ag = 1'b0; last_bg = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_a_gnt", a_bus.gnt, 0);
    chk("rst_b_gnt", b_bus.gnt, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_a_rvalid", a_bus.rvalid, 0);
    chk("rst_a_rdata", a_bus.rdata, 0);
    chk("rst_b_rvalid", b_bus.rvalid, 0);
    chk("rst_b_rdata", b_bus.rdata, 0);
  endtask

  task automatic model_check();
    logic        bp, eag, ebg, w;
    logic [31:0] ad, wd;
    int          s;
`ifdef ARB_ROUND_ROBIN_EN
    bp = last_a;
`else
    bp = (denied == MAX_WAIT);
`endif
    eag = a_bus.req && !(b_bus.req && bp);
    ebg = b_bus.req && !eag;
    obs_bg = b_bus.gnt;
    chk("a_gnt", a_bus.gnt, eag);
    chk("b_gnt", b_bus.gnt, ebg);
    chk("ram_we", ram_we, exp_we);
    chk("ram_addr", ram_addr, exp_addr);
    chk("ram_wdata", ram_wdata, exp_wd);
    s = cyc % 4;
    chk("a_rvalid", a_bus.rvalid, slot_v[s] && !slot_b[s]);
    chk("b_rvalid", b_bus.rvalid, slot_v[s] && slot_b[s]);
    chk("rvalid_excl", a_bus.rvalid & b_bus.rvalid, 0);
    if (slot_v[s]) begin
      if (slot_b[s]) exp_brd = slot_d[s];
      else           exp_ard = slot_d[s];
    end
    slot_v[s] = 1'b0;
    chk("a_rdata", a_bus.rdata, exp_ard);
    chk("b_rdata", b_bus.rdata, exp_brd);

    exp_we = 1'b0;
    if (eag || ebg) begin
      w  = ebg ? b_bus.we    : a_bus.we;
      ad = ebg ? b_bus.addr  : a_bus.addr;
      wd = ebg ? b_bus.wdata : a_bus.wdata;
      exp_we = w; exp_addr = ad; exp_wd = wd;
      if (w) begin
        refmem[ad[7:0]] = wd;
      end else begin
        slot_v[(cyc + 3) % 4] = 1'b1;
        slot_b[(cyc + 3) % 4] = ebg;
        slot_d[(cyc + 3) % 4] = refmem[ad[7:0]];
      end
    end
    if (b_bus.req && !ebg) denied = (denied < MAX_WAIT) ? denied + 1 : MAX_WAIT;
    else                   denied = 0;
    if (a_bus.req && b_bus.req) last_a = eag;
    last_ag = eag; last_bg = ebg;
    cyc++;
  endtask

  task automatic run_cycle(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                           input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
    a_bus.req = ar; a_bus.we = aw; a_bus.addr = aa; a_bus.wdata = ad;
    b_bus.req = br; b_bus.we = bw; b_bus.addr = ba; b_bus.wdata = bd;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic        ar, aw, br, bw;
    logic [31:0] aa, ad, ba, bd;
    int          first_b, n_b, exp_first, exp_nb;

    for (int i = 0; i < 256; i++) refmem[i] = init_val(i);
    reset_model();
    a_bus.req = 1'b1; a_bus.we = 1'b0; a_bus.addr = '0; a_bus.wdata = '0;
    b_bus.req = 1'b1; b_bus.we = 1'b0; b_bus.addr = '0; b_bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    init_done = 1'b1;
    check_reset_state();
    a_bus.req = 1'b0; b_bus.req = 1'b0;
    rst = 1'b1;

    // CPU write then read of the same address
    idle(2);
    run_cycle(1, 1, 32'h1, 32'hFA32, 0, 0, 0, 0);
    run_cycle(1, 0, 32'h1, 32'h0, 0, 0, 0, 0);
    idle(4);
    chk("wr_rd_data", a_bus.rdata, 32'hFA32);

    // A and B reads on consecutive cycles
    run_cycle(1, 0, 32'h3, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 1, 0, 32'h5, 0);
    idle(4);
    chk("il_a_rdata", a_bus.rdata, 32'h0000_EA99);
    chk("il_b_rdata", b_bus.rdata, 32'h0000_1234);

    idle(10);

    // reset asserted one cycle after a read grant; the read must never return
    run_cycle(1, 0, 32'h7, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check_reset_state();
    reset_model();
    @(posedge clk);
    #1;
    a_bus.req = 1'b0;
    rst = 1'b1;
    idle(6);

    // both masters requesting continuously
    first_b = -1; n_b = 0;
    for (int i = 1; i <= 20; i++) begin
      run_cycle(1, 0, 32'(i % 16), 0, 1, 0, 32'((i + 7) % 16), 0);
      if (obs_bg) begin
        n_b++;
        if (first_b < 0) first_b = i;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_first = 2;  exp_nb = 10;
`else
    exp_first = MAX_WAIT + 1; exp_nb = 2;
`endif
    chk("contend_first_b", 64'(first_b), 64'(exp_first));
    chk("contend_b_count", 64'(n_b), 64'(exp_nb));
    idle(4);

    // random traffic; ungranted requests are held stable
    ar = 0; aw = 0; aa = 0; ad = 0; br = 0; bw = 0; ba = 0; bd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ar || last_ag) begin
        ar = ($urandom % 4) != 0; aw = 1'($urandom % 2);
        aa = $urandom % 16;       ad = $urandom;
      end
      if (!br || last_bg) begin
        br = ($urandom % 2) != 0; bw = 1'($urandom % 2);
        ba = $urandom % 16;       bd = $urandom;
      end
      run_cycle(ar, aw, aa, ad, br, bw, ba, bd);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
